onn_recall_ctrl: RTL and testbench
==================================

ONN_RECALL_CTRL -- requirements
Module: onn_recall_ctrl

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 15, neuron count and state-vector width.
REQ-002 SHALL have parameter MAX_ITERS, default 64, the iteration limit before timeout (range 1..255).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request a recall run; honoured only in IDLE.
REQ-006 SHALL have port mode  input  1  update mode, sampled with start: 0 = synchronous (all neurons per cycle), 1 = sequential (one neuron per cycle).
REQ-007 SHALL have port pattern_in  input  NUM_NEURONS  initial neuron states, sampled with start.
REQ-008 SHALL have port abort  input  1  cancel a run in progress.
REQ-009 SHALL have port nin  input  NUM_NEURONS  next-state vector from the combinational synapse block.
REQ-010 SHALL have port nout  output  NUM_NEURONS  current neuron-state register, driven to the synapse block.
REQ-011 SHALL have port busy  output  1  high in RUN.
REQ-012 SHALL have port res_valid  output  1  result available, held until res_ack.
REQ-013 SHALL have port res_ack  input  1  result consumed.
REQ-014 SHALL have port converged  output  1  run reached a fixed point (valid while res_valid).
REQ-015 SHALL have port iter_count  output  8  iterations performed (valid while res_valid).

Function
REQ-016 SHALL implement states IDLE, RUN and DONE.
REQ-017 In IDLE with start=1: nout <= pattern_in, latch mode, iter_count <= 0, neuron index <= 0, change flag <= 0, go to RUN next cycle.
REQ-018 nout SHALL change only on the start load or by the updates defined below; nin is sampled once per RUN cycle (single-cycle combinational path).
REQ-019 Synchronous mode, each RUN cycle: iter_count += 1; if nin == nout, go to DONE with converged=1 and nout unchanged; otherwise nout <= nin.
REQ-020 Sequential mode, each RUN cycle: nout[idx] <= nin[idx], change flag set if the bit differs, idx += 1; idx wraps from NUM_NEURONS-1 to 0.
REQ-021 Sequential mode, at idx == NUM_NEURONS-1: iter_count += 1 (one sweep = one iteration); if no bit changed during the sweep, including this cycle, go to DONE with converged=1; else clear the change flag.
REQ-022 If an iteration completes without convergence and iter_count reaches MAX_ITERS, SHALL go to DONE with converged=0; convergence on the same iteration takes priority.
REQ-023 DONE: res_valid=1; nout, converged and iter_count held stable; res_ack=1 returns to IDLE next cycle with res_valid=0.
REQ-024 abort=1 in RUN SHALL return to IDLE next cycle with no result (res_valid stays 0), nout and iter_count holding their last values; abort in IDLE/DONE ignored.
REQ-025 start in RUN or DONE SHALL be ignored; start and abort together in IDLE -> start wins.
REQ-026 busy SHALL be 1 exactly in RUN; busy and res_valid are never both 1.
REQ-027 iter_count SHALL never exceed MAX_ITERS and never wrap.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, nout=0, busy=0, res_valid=0, converged=0, iter_count=0, idx=0, change flag=0, including mid-run.
REQ-029 First start honoured on the first rising edge after rst_n deasserts.

Verification
REQ-030 Stub nin=nout, mode=0, pattern_in=15'h1234, start -> one RUN cycle, res_valid=1, converged=1, iter_count=1, nout=15'h1234.
REQ-031 Stub nin=~nout, mode=0, MAX_ITERS=64 -> DONE after 64 RUN cycles, converged=0, iter_count=64.
REQ-032 Stub nin=15'h2AAA constant, mode=1, pattern_in=0 -> sweep 1 changes bits, sweep 2 none; converged=1, iter_count=2, nout=15'h2AAA, 30 RUN cycles.
REQ-033 abort asserted on the 5th RUN cycle -> IDLE next cycle, res_valid never 1; a following start runs normally.
REQ-034 rst_n pulsed low mid-run with start held high -> all outputs reset immediately; start re-sampled after release.
REQ-035 res_ack withheld 10 cycles in DONE -> outputs stable, start ignored; res_ack -> IDLE.

Source files
------------

// File: rtl/onn_recall_ctrl.sv
// Oscillatory/Hopfield neural-network recall controller: loads a pattern and iterates the neuron state to a fixed point or to a timeout.
// Latency: one RUN cycle per synchronous iteration, NUM_NEURONS RUN cycles per sequential sweep; DONE follows the deciding cycle.
// Backpressure: the result is held in DONE until res_ack; start is ignored outside IDLE; abort cancels a run with no result.
//
// Ports:
//   clk, rst_n              - clock (rising edge), asynchronous active-low reset
//   start, mode, pattern_in - launch a run; mode 0 = all neurons per cycle, 1 = one neuron per cycle
//   abort                   - cancel a run in progress
//   nin / nout              - next-state vector from the synapse block / current neuron-state register
//   busy, res_valid, res_ack, converged, iter_count - status and result handshake
module onn_recall_ctrl #(
    parameter int NUM_NEURONS = 15,
    parameter int MAX_ITERS   = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   mode,
    input  logic [NUM_NEURONS-1:0] pattern_in,
    input  logic                   abort,
    input  logic [NUM_NEURONS-1:0] nin,
    output logic [NUM_NEURONS-1:0] nout,
    output logic                   busy,
    output logic                   res_valid,
    input  logic                   res_ack,
    output logic                   converged,
    output logic [7:0]             iter_count
);

    localparam int             IW       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_NEURONS - 1);
    localparam logic [7:0]     MAX8     = 8'(MAX_ITERS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [NUM_NEURONS-1:0] nout_q, nout_d;
    logic                   mode_q, mode_d;
    logic [7:0]             iter_q, iter_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   chg_q, chg_d;
    logic                   conv_q, conv_d;

    logic [7:0]             iter_inc;
    logic                   last_iter;
    logic                   chg_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            nout_q  <= '0;
            mode_q  <= 1'b0;
            iter_q  <= '0;
            idx_q   <= '0;
            chg_q   <= 1'b0;
            conv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            nout_q  <= nout_d;
            mode_q  <= mode_d;
            iter_q  <= iter_d;
            idx_q   <= idx_d;
            chg_q   <= chg_d;
            conv_q  <= conv_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        nout_d    = nout_q;
        mode_d    = mode_q;
        iter_d    = iter_q;
        idx_d     = idx_q;
        chg_d     = chg_q;
        conv_d    = conv_q;
        iter_inc  = iter_q + 8'd1;
        // MAX_ITERS <= 255, so iter_count stops at the limit and never wraps.
        last_iter = (iter_inc == MAX8);
        // Sweep-level change flag including the bit being updated this cycle.
        chg_now   = chg_q | (nin[idx_q] != nout_q[idx_q]);

        unique case (state_q)
            S_IDLE: begin
                // abort is irrelevant here, so start always wins.
                if (start) begin
                    state_d = S_RUN;
                    nout_d  = pattern_in;
                    mode_d  = mode;
                    iter_d  = '0;
                    idx_d   = '0;
                    chg_d   = 1'b0;
                    conv_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    // Cancel without updating nout or iter_count.
                    state_d = S_IDLE;
                end else if (!mode_q) begin
                    iter_d = iter_inc;
                    if (nin == nout_q) begin
                        state_d = S_DONE;
                        conv_d  = 1'b1;
                    end else begin
                        nout_d = nin;
                        if (last_iter) state_d = S_DONE;
                    end
                end else begin
                    nout_d[idx_q] = nin[idx_q];
                    if (idx_q == LAST_IDX) begin
                        idx_d  = '0;
                        iter_d = iter_inc;
                        chg_d  = 1'b0;
                        // Convergence on the final sweep beats the timeout.
                        if (!chg_now) begin
                            state_d = S_DONE;
                            conv_d  = 1'b1;
                        end else if (last_iter) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                        chg_d = chg_now;
                    end
                end
            end
            S_DONE: begin
                if (res_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign nout       = nout_q;
    assign busy       = (state_q == S_RUN);
    assign res_valid  = (state_q == S_DONE);
    assign converged  = conv_q;
    assign iter_count = iter_q;

endmodule

// File: tb/tb_onn_recall_ctrl.sv
module tb_onn_recall_ctrl;

    localparam int N    = 15;
    localparam int MAXI = 64;

    logic          clk = 1'b0;
    logic          rst_n, start, mode, abort, res_ack;
    logic [N-1:0]  pattern_in, nin, nout;
    logic          busy, res_valid, converged;
    logic [7:0]    iter_count;

    int            kind;
    logic [N-1:0]  ka, kb, kc;
    int            n_cmp  = 0;
    int            n_fail = 0;

    onn_recall_ctrl #(.NUM_NEURONS(N), .MAX_ITERS(MAXI)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .pattern_in(pattern_in), .abort(abort), .nin(nin), .nout(nout),
        .busy(busy), .res_valid(res_valid), .res_ack(res_ack),
        .converged(converged), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    // Synapse-block stand-in: next state as a function of the current state.
    function automatic logic [N-1:0] stub(input int k, input logic [N-1:0] x,
                                          input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [N-1:0] c);
        case (k)
            0:       return x;
            1:       return ~x;
            2:       return 15'h2AAA;
            3:       return (x & a) | b;
            default: return {x[N-2:0], x[N-1]} ^ c;
        endcase
    endfunction

    always_comb nin = stub(kind, nout, ka, kb, kc);

    // Reference: iterate the recall rules directly on a state vector.
    task automatic model(input logic [N-1:0] pat, input logic md,
                         output logic [N-1:0] fin, output logic conv,
                         output int iters, output int cyc);
        logic [N-1:0] s, n;
        bit changed;
        s = pat; conv = 0; iters = 0; cyc = 0;
        while (iters < MAXI && !conv) begin
            if (!md) begin
                cyc++;
                n = stub(kind, s, ka, kb, kc);
                iters++;
                if (n == s) conv = 1;
                else s = n;
            end else begin
                changed = 0;
                for (int i = 0; i < N; i++) begin
                    cyc++;
                    n = stub(kind, s, ka, kb, kc);
                    if (n[i] != s[i]) changed = 1;
                    s[i] = n[i];
                end
                iters++;
                if (!changed) conv = 1;
            end
        end
        fin = s;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [N-1:0] p, input logic m);
        start = 1'b1; pattern_in = p; mode = m;
        tick;
        start = 1'b0;
    endtask

    // Counts RUN cycles; bounded so a stuck DUT still reaches the summary.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (busy && cyc < 3000) begin
            cyc++;
            tick;
        end
    endtask

    task automatic do_ack;
        res_ack = 1'b1;
        tick;
        res_ack = 1'b0;
    endtask

    task automatic test_reset;
        int cyc;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0; res_ack = 1'b0;
        pattern_in = '0; kind = 0; ka = '0; kb = '0; kc = '0;
        #1;
        n_cmp++;
        if ({nout, busy, res_valid, converged, iter_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: nout=%h busy=%b vld=%b conv=%b iter=%0d, want all zero",
                     nout, busy, res_valid, converged, iter_count);
        end
        start = 1'b1; pattern_in = 15'h0F0F; mode = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || nout !== 15'h0F0F) begin
            n_fail++;
            $display("FAIL first_start: busy=%b nout=%h, want 1 0f0f", busy, nout);
        end
        wait_done(cyc);
        do_ack;
    endtask

    task automatic test_sync_converge;
        int cyc;
        kind = 0;
        launch(15'h1234, 1'b0);
        wait_done(cyc);
        n_cmp++;
        if (cyc !== 1 || res_valid !== 1'b1 || converged !== 1'b1 || iter_count !== 8'd1 || nout !== 15'h1234) begin
            n_fail++;
            $display("FAIL sync_converge: cyc=%0d vld=%b conv=%b iter=%0d nout=%h, want 1 1 1 1 1234",
                     cyc, res_valid, converged, iter_count, nout);
        end
        do_ack;
        n_cmp++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_idle: vld=%b busy=%b, want 0 0", res_valid, busy);
        end
    endtask

    task automatic test_sync_timeout;
        int cyc;
        logic [N-1:0] p;
        kind = 1;
        p = N'($urandom);
        launch(p, 1'b0);
        wait_done(cyc);
        n_cmp++;
        if (cyc !== MAXI || res_valid !== 1'b1 || converged !== 1'b0 || iter_count !== 8'(MAXI) || nout !== p) begin
            n_fail++;
            $display("FAIL sync_timeout: cyc=%0d vld=%b conv=%b iter=%0d nout=%h, want %0d 1 0 %0d %h",
                     cyc, res_valid, converged, iter_count, nout, MAXI, MAXI, p);
        end
        do_ack;
    endtask

    task automatic test_seq;
        int cyc;
        kind = 2;
        launch('0, 1'b1);
        wait_done(cyc);
        n_cmp++;
        if (cyc !== 30 || converged !== 1'b1 || iter_count !== 8'd2 || nout !== 15'h2AAA) begin
            n_fail++;
            $display("FAIL seq_sweep: cyc=%0d conv=%b iter=%0d nout=%h, want 30 1 2 2aaa",
                     cyc, converged, iter_count, nout);
        end
        do_ack;
    endtask

    task automatic test_abort;
        int cyc;
        bit seen;
        logic [N-1:0] p;
        kind = 1;
        p = N'($urandom);
        launch(p, 1'b0);
        repeat (4) tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || iter_count !== 8'd4 || nout !== p) begin
            n_fail++;
            $display("FAIL abort: busy=%b vld=%b iter=%0d nout=%h, want 0 0 4 %h",
                     busy, res_valid, iter_count, nout, p);
        end
        seen = 0;
        repeat (5) begin
            tick;
            if (res_valid || busy) seen = 1;
        end
        n_cmp++;
        if (seen) begin
            n_fail++;
            $display("FAIL abort_quiet: activity after abort = 1, want 0");
        end
        kind = 0;
        launch(15'h0555, 1'b0);
        wait_done(cyc);
        n_cmp++;
        if (cyc !== 1 || converged !== 1'b1 || iter_count !== 8'd1 || nout !== 15'h0555) begin
            n_fail++;
            $display("FAIL abort_restart: cyc=%0d conv=%b iter=%0d nout=%h, want 1 1 1 0555",
                     cyc, converged, iter_count, nout);
        end
        do_ack;
    endtask

    task automatic test_reset_midrun;
        kind = 1;
        launch(15'h7001, 1'b0);
        repeat (3) tick;
        start = 1'b1; pattern_in = 15'h3C3C; mode = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({nout, busy, res_valid, converged, iter_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_midrun: nout=%h busy=%b vld=%b conv=%b iter=%0d, want all zero",
                     nout, busy, res_valid, converged, iter_count);
        end
        #2 rst_n = 1'b1;
        tick;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || nout !== 15'h3C3C || iter_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_resample: busy=%b nout=%h iter=%0d, want 1 3c3c 0", busy, nout, iter_count);
        end
        abort = 1'b1;
        tick;
        abort = 1'b0;
    endtask

    task automatic test_ack_hold;
        int cyc;
        kind = 2;
        launch('0, 1'b1);
        wait_done(cyc);
        for (int i = 0; i < 10; i++) begin
            start = 1'b1; pattern_in = N'($urandom); mode = 1'($urandom);
            tick;
            n_cmp++;
            if ({res_valid, busy, converged, iter_count, nout} !== {1'b1, 1'b0, 1'b1, 8'd2, 15'h2AAA}) begin
                n_fail++;
                $display("FAIL ack_hold[%0d]: vld=%b busy=%b conv=%b iter=%0d nout=%h, want 1 0 1 2 2aaa",
                         i, res_valid, busy, converged, iter_count, nout);
            end
        end
        start = 1'b0;
        do_ack;
        n_cmp++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_release: vld=%b busy=%b, want 0 0", res_valid, busy);
        end
    endtask

    task automatic test_random;
        int cyc, e_iters, e_cyc;
        logic [N-1:0] p, e_fin;
        logic m, e_conv;
        for (int r = 0; r < 24; r++) begin
            kind = $urandom_range(0, 4);
            ka = N'($urandom); kb = N'($urandom); kc = N'($urandom);
            p  = N'($urandom);
            m  = 1'($urandom);
            model(p, m, e_fin, e_conv, e_iters, e_cyc);
            launch(p, m);
            wait_done(cyc);
            n_cmp++;
            if (cyc !== e_cyc || res_valid !== 1'b1 || converged !== e_conv ||
                iter_count !== 8'(e_iters) || nout !== e_fin) begin
                n_fail++;
                $display("FAIL random[%0d] k=%0d m=%b: cyc=%0d vld=%b conv=%b iter=%0d nout=%h, want %0d 1 %b %0d %h",
                         r, kind, m, cyc, res_valid, converged, iter_count, nout,
                         e_cyc, e_conv, e_iters, e_fin);
            end
            do_ack;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_sync_converge;
        test_sync_timeout;
        test_seq;
        test_abort;
        test_reset_midrun;
        test_ack_hold;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
